ramp_level_decoder: RTL and testbench

//   Receive-side counterpart of the 10-level ramp sample generator. Slices each incoming
//   8-bit sample (ADC / loopback) to the nearest of the 10 nominal levels
//   {0,28,56,85,113,141,170,198,226,255} and outputs the level index 0..9.

---
 rtl/ramp_level_decoder.sv | 138 +++++++++++++
 tb/tb_ramp_level_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_level_decoder.sv
// Slices 8-bit ramp samples to 10 nominal levels and tracks the ascending 0..9 sequence.
// Optional seq_err counter built when RAMP_DEC_ERRCNT_EN is defined.
module ramp_level_decoder #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_sample,
  output logic             out_valid,
  output logic [3:0]       level,
  output logic             exact,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] THR [9]  = '{8'd14, 8'd42, 8'd71, 8'd99, 8'd127,
                                      8'd156, 8'd184, 8'd212, 8'd241};
  localparam logic [7:0] NOM [10] = '{8'd0, 8'd28, 8'd56, 8'd85, 8'd113,
                                      8'd141, 8'd170, 8'd198, 8'd226, 8'd255};

  typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

  state_t     r_state, w_state_nx;
  logic [3:0] r_prev, r_match_cnt, r_miss_cnt;
  logic [3:0] w_match_nx, w_miss_nx;
  logic [3:0] w_level, w_expected;
  logic       w_exact, w_match, w_seq_err;

  logic       r_out_valid, r_exact, r_locked, r_seq_err;
  logic [3:0] r_level;

  // Level is the count of thresholds at or below the sample, so it saturates at 0 and 9.
  always_comb begin
    w_level = 4'd0;
    for (int i = 0; i < 9; i++)
      if (in_sample >= THR[i]) w_level = w_level + 4'd1;
    w_exact = (in_sample == NOM[w_level]);
  end

  assign w_expected = (r_prev == 4'd9) ? 4'd0 : r_prev + 4'd1;
  assign w_match    = (w_level == w_expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
    end else begin
      r_state     <= w_state_nx;
      r_match_cnt <= w_match_nx;
      r_miss_cnt  <= w_miss_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_match_nx = r_match_cnt;
    w_miss_nx  = r_miss_cnt;
    w_seq_err  = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_SEARCH: begin
          w_state_nx = S_TRACK;
          w_match_nx = 4'd0;
        end
        S_TRACK: begin
          if (w_match) begin
            w_match_nx = r_match_cnt + 4'd1;
            if (r_match_cnt + 4'd1 == 4'(LOCK_CNT)) begin
              w_state_nx = S_LOCKED;
              w_miss_nx  = 4'd0;
            end
          end else begin
            w_match_nx = 4'd0;
          end
        end
        S_LOCKED: begin
          if (w_match) begin
            w_miss_nx = 4'd0;
          end else begin
            w_seq_err = 1'b1;
            w_miss_nx = r_miss_cnt + 4'd1;
            if (r_miss_cnt + 4'd1 == 4'(UNLOCK_CNT)) begin
              w_state_nx = S_SEARCH;
              w_match_nx = 4'd0;
            end
          end
        end
        default: w_state_nx = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_level     <= 4'd0;
      r_exact     <= 1'b0;
      r_locked    <= 1'b0;
      r_seq_err   <= 1'b0;
      r_prev      <= 4'd0;
    end else if (in_valid) begin
      r_out_valid <= 1'b1;
      r_level     <= w_level;
      r_exact     <= w_exact;
      r_locked    <= (w_state_nx == S_LOCKED);
      r_seq_err   <= w_seq_err;
      r_prev      <= w_level;
    end else begin
      r_out_valid <= 1'b0;
      r_seq_err   <= 1'b0;
    end
  end

`ifdef RAMP_DEC_ERRCNT_EN
  logic [ERR_W-1:0] r_err_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_count <= '0;
    else if (in_valid && w_seq_err && (r_err_count != {ERR_W{1'b1}}))
      r_err_count <= r_err_count + 1'b1;
  end
  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign exact     = r_exact;
  assign locked    = r_locked;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_ramp_level_decoder.sv
// Randomized self-checking bench for ramp_level_decoder against a sequence-tracking reference model.
module tb_ramp_level_decoder;
  localparam int ERR_W = 16;
  localparam int LOCK = 4;
  localparam int UNLOCK = 3;
`ifdef RAMP_DEC_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [7:0] in_sample = 8'd0;
  logic out_valid, exact, locked, seq_err;
  logic [3:0] level;
  logic [ERR_W-1:0] err_count;

  int tests = 0, fails = 0;

  ramp_level_decoder #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(out_valid), .level(level), .exact(exact), .locked(locked),
    .seq_err(seq_err), .err_count(err_count));

  always #5 clk = ~clk;

  int nom [10] = '{0, 28, 56, 85, 113, 141, 170, 198, 226, 255};
  int thr [9]  = '{14, 42, 71, 99, 127, 156, 184, 212, 241};

  // Reference model: mode 0=searching, 1=tracking, 2=locked
  int m_mode, m_prev, m_run, m_bad, m_errs;
  logic m_ov, m_ex, m_lk, m_se;
  logic [3:0] m_lvl;

  wire [ERR_W+7:0] dut_vec = {out_valid, level, exact, locked, seq_err, err_count};
  logic [ERR_W+7:0] exp_vec;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_bad = 0; m_errs = 0;
    m_ov = 0; m_ex = 0; m_lk = 0; m_se = 0; m_lvl = 0;
  endtask

  task automatic model_step(input logic v, input int s);
    int lv;
    bit ok;
    int ec;
    m_se = 0;
    if (v) begin
      lv = 0;
      foreach (thr[i]) if (s >= thr[i]) lv++;
      ok = (lv == (m_prev + 1) % 10);
      if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        if (ok) begin
          m_run++;
          if (m_run == LOCK) begin m_mode = 2; m_bad = 0; end
        end else m_run = 0;
      end else begin
        if (ok) m_bad = 0;
        else begin
          m_se = 1; m_bad++; m_errs++;
          if (m_bad == UNLOCK) begin m_mode = 0; m_run = 0; end
        end
      end
      m_prev = lv;
      m_ov = 1; m_lvl = 4'(lv); m_ex = (s == nom[lv]); m_lk = (m_mode == 2);
    end else m_ov = 0;
    ec = ERRCNT ? ((m_errs > 65535) ? 65535 : m_errs) : 0;
    exp_vec = {m_ov, m_lvl, m_ex, m_lk, m_se, 16'(ec)};
  endtask

  task automatic apply(input logic v, input int s);
    @(negedge clk);
    in_valid = v; in_sample = 8'(s);
    @(posedge clk);
    model_step(v, s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    #2; rst = 1'b0;
    model_reset();
    exp_vec = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (dut_vec !== '0) begin
      $display("FAIL reset_init got=%h exp=0", dut_vec); fails++;
    end
    for (int i = 0; i < 7; i++) apply(1'b1, nom[i]);
    tests++;
    if (locked !== 1'b1) begin
      $display("FAIL reset_prelock got=%b exp=1", locked); fails++;
    end
    @(posedge clk); #3; rst = 1'b1; #1;
    tests++;
    if (dut_vec !== '0) begin
      $display("FAIL reset_async got=%h exp=0", dut_vec); fails++;
    end
    @(negedge clk); rst = 1'b0; model_reset();
    apply(1'b1, nom[7]);
    tests++;
    if (dut_vec !== exp_vec || locked !== 1'b0) begin
      $display("FAIL reset_after got=%h exp=%h", dut_vec, exp_vec); fails++;
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int i = 0; i < 25; i++) begin
      apply(1'b1, nom[i % 10]);
      tests++;
      if (dut_vec !== exp_vec || level !== 4'(i % 10) || exact !== 1'b1 || locked !== (i >= 4)) begin
        $display("FAIL ramp[%0d] got=%h exp=%h", i, dut_vec, exp_vec); fails++;
      end
    end
  endtask

  task automatic test_thresholds();
    int smp [17] = '{13, 14, 70, 71, 240, 241, 255, 0, 28, 56, 85, 113, 141, 170, 198, 226, 41};
    int lvl [17] = '{0, 1, 2, 3, 8, 9, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8, 1};
    int ex  [17] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    foreach (smp[i]) begin
      apply(1'b1, smp[i]);
      tests++;
      if (dut_vec !== exp_vec || level !== 4'(lvl[i]) || exact !== ex[i][0]) begin
        $display("FAIL thresh s=%0d got lvl=%0d ex=%b exp lvl=%0d ex=%0d", smp[i], level, exact, lvl[i], ex[i]);
        fails++;
      end
    end
  endtask

  task automatic test_noise();
    int off, s;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      off = $urandom_range(10, 1);
      if (i % 10 == 9 || (i % 10 != 0 && $urandom_range(1, 0) == 1)) off = -off;
      s = nom[i % 10] + off;
      apply(1'b1, s);
      tests++;
      if (dut_vec !== exp_vec || level !== 4'(i % 10) || exact !== 1'b0 || locked !== (i >= 4)) begin
        $display("FAIL noise[%0d] s=%0d got=%h exp=%h", i, s, dut_vec, exp_vec); fails++;
      end
    end
  endtask

  task automatic test_seq_err();
    int tail [6] = '{0, 1, 2, 5, 5, 5};
    do_reset();
    for (int i = 0; i < 10; i++) apply(1'b1, nom[i]);
    foreach (tail[i]) begin
      apply(1'b1, nom[tail[i]]);
      tests++;
      if (dut_vec !== exp_vec || seq_err !== (i >= 3) || locked !== (i < 5)) begin
        $display("FAIL seqerr[%0d] got=%h exp=%h", i, dut_vec, exp_vec); fails++;
      end
    end
    apply(1'b0, 0);
    tests++;
    if (err_count !== (ERRCNT ? 16'd3 : 16'd0) || seq_err !== 1'b0) begin
      $display("FAIL errcount got=%0d exp=%0d", err_count, ERRCNT ? 3 : 0); fails++;
    end
  endtask

  task automatic test_gaps();
    int g;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apply(1'b1, nom[i % 10]);
      tests++;
      if (dut_vec !== exp_vec || level !== 4'(i % 10) || locked !== (i >= 4)) begin
        $display("FAIL gap_v[%0d] got=%h exp=%h", i, dut_vec, exp_vec); fails++;
      end
      g = $urandom_range(3, 1);
      for (int k = 0; k < g; k++) begin
        apply(1'b0, $urandom_range(255, 0));
        tests++;
        if (dut_vec !== exp_vec || out_valid !== 1'b0 || level !== 4'(i % 10)) begin
          $display("FAIL gap_hold[%0d] got=%h exp=%h", i, dut_vec, exp_vec); fails++;
        end
      end
    end
  endtask

  task automatic test_random();
    int lv, s, r;
    do_reset();
    lv = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99, 0);
      if (r < 15) begin
        apply(1'b0, $urandom_range(255, 0));
      end else begin
        if (r < 80) lv = (lv + 1) % 10;
        else if (r < 90) lv = $urandom_range(9, 0);
        s = nom[lv] + $urandom_range(20, 0) - 10;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        if (r >= 97) s = $urandom_range(255, 0);
        apply(1'b1, s);
      end
      tests++;
      if (dut_vec !== exp_vec) begin
        $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec); fails++;
      end
    end
  endtask

  initial begin
    model_reset();
    exp_vec = '0;
    rst = 1'b1;
    #12 rst = 1'b0;
    test_reset();
    test_ramp();
    test_thresholds();
    test_noise();
    test_seq_err();
    test_gaps();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
